// File: rtl/alu_pkg.sv
// Shared ALU types: data width, divide ops, divider FSM states.
// No ports; imported by the divider and its step datapath.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract.
// Ports: rem/next_bit/divisor in; rem_next and quo_bit out.
module div_step
  import alu_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             quo_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < divisor on entry, so the shifted value needs one extra bit
  // and a non-negative difference always fits back into WIDTH bits.
  always_comb begin
    shifted  = {rem, next_bit};
    diff     = shifted - {1'b0, divisor};
    quo_bit  = ~diff[WIDTH];
    rem_next = quo_bit ? diff[WIDTH-1:0]
                       : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit, one quotient bit per cycle.
// Ports: clk, rst, start, op, dividend, divisor -> busy, done, result.
module iter_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t state;

  logic             want_rem;
  logic             q_neg;
  logic             r_neg;
  logic             spec;
  logic [WIDTH-1:0] spec_res;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dsr;
  logic [CW-1:0]    cnt;

  logic             is_signed;
  logic             is_rem;
  logic             a_sign;
  logic             b_sign;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             ovf;
  logic [WIDTH-1:0] spec_val;
  logic             accept;
  logic [WIDTH-1:0] rem_nx;
  logic             qbit;
  logic [WIDTH-1:0] fixed;

  always_comb begin
    is_signed = 1'b0;
    is_rem    = 1'b0;
    unique case (div_op_t'(op))
      DIV:  is_signed = 1'b1;
      DIVU: is_signed = 1'b0;
      REM: begin
        is_signed = 1'b1;
        is_rem    = 1'b1;
      end
      REMU: is_rem = 1'b1;
      default: ;
    endcase
  end

  assign a_sign = is_signed & dividend[WIDTH-1];
  assign b_sign = is_signed & divisor[WIDTH-1];
  assign a_mag  = a_sign ? -dividend : dividend;
  assign b_mag  = b_sign ? -divisor : divisor;

  assign div_zero = (divisor == '0);
  assign ovf = is_signed
             & (dividend == MIN_NEG)
             & (divisor == '1);

  // Divide-by-zero wins over overflow; it can't overlap anyway.
  always_comb begin
    if (div_zero)
      spec_val = is_rem ? dividend : '1;
    else
      spec_val = is_rem ? '0 : dividend;
  end

  // DONE may accept too, giving back-to-back issue.
  assign accept = start & (state != CALC);

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem),
    .next_bit(quo[WIDTH-1]),
    .divisor (dsr),
    .rem_next(rem_nx),
    .quo_bit (qbit)
  );

  always_comb begin
    if (spec)
      fixed = spec_res;
    else if (want_rem)
      fixed = r_neg ? -rem : rem;
    else
      fixed = q_neg ? -quo : quo;
  end

  // Outputs are registered from the state of the previous cycle,
  // so busy/done/result trail the FSM by one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      want_rem <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      spec     <= 1'b0;
      spec_res <= '0;
      quo      <= '0;
      rem      <= '0;
      dsr      <= '0;
      cnt      <= '0;
    end else begin
      busy <= (state == CALC);
      done <= (state == DONE);
      if (state == DONE)
        result <= fixed;

      if (accept) begin
        want_rem <= is_rem;
        q_neg    <= a_sign ^ b_sign;
        r_neg    <= a_sign;
        spec     <= div_zero | ovf;
        spec_res <= spec_val;
        quo      <= a_mag;
        rem      <= '0;
        dsr      <= b_mag;
        cnt      <= '0;
        state    <= (div_zero | ovf) ? DONE : CALC;
      end else begin
        unique case (state)
          CALC: begin
            quo <= {quo[WIDTH-2:0], qbit};
            rem <= rem_nx;
            cnt <= cnt + 1'b1;
            if (cnt == LAST)
              state <= DONE;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed RV32M cases plus random.
// Reference model uses plain signed/unsigned arithmetic.
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  iter_divider #(
    .WIDTH(32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .dividend(dividend),
    .divisor (divisor),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(
    input logic [1:0]  o,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint sa, sb, q, r;
    if (b == 0)
      return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
        return o[1] ? 32'h0 : a;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return o[1] ? 32'(r) : 32'(q);
    end
    return o[1] ? (a % b) : (a / b);
  endfunction

  function automatic int lat_of(
    input logic [1:0]  o,
    input logic [31:0] a,
    input logic [31:0] b
  );
    if (b == 0) return 1;
    if (!o[0] && a == 32'h8000_0000
        && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic launch(
    input logic [1:0]  o,
    input logic [31:0] a,
    input logic [31:0] b
  );
    @(negedge clk);
    start    = 1'b1;
    op       = o;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    op       = 2'($urandom);
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_done(
    output int lat,
    output int nbusy
  );
    lat   = 0;
    nbusy = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (busy) nbusy++;
    end while (!done && lat < 100);
  endtask

  task automatic check_op(
    input string       tag,
    input logic [31:0] exp,
    input int          elat,
    input bit          tail
  );
    int lat, nb;
    wait_done(lat, nb);
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " result"}, result, exp);
    chk({tag, " busy cycles"}, 32'(nb),
        32'(elat == 33 ? 32 : 0));
    if (tail) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, " done pulse"}, 32'(done), 32'd0);
      chk({tag, " hold"}, result, exp);
    end
  endtask

  task automatic do_op(
    input string       tag,
    input logic [1:0]  o,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] exp,
    input int          elat
  );
    launch(o, a, b);
    check_op(tag, exp, elat, 1'b1);
  endtask

  initial begin
    bit seen;
    rst      = 1'b1;
    start    = 1'b0;
    op       = 2'b00;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    rst = 1'b0;

    do_op("divu 100/7", 2'b01, 32'd100, 32'd7,
          32'd14, 33);
    do_op("remu 100/7", 2'b11, 32'd100, 32'd7,
          32'd2, 33);
    do_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2,
          32'hFFFF_FFFD, 33);
    do_op("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2,
          32'hFFFF_FFFF, 33);
    do_op("div 7/-2", 2'b00, 32'd7, 32'hFFFF_FFFE,
          32'hFFFF_FFFD, 33);
    do_op("divu /0", 2'b01, 32'h1234_5678, 32'd0,
          32'hFFFF_FFFF, 1);
    do_op("rem /0", 2'b10, 32'h1234_5678, 32'd0,
          32'h1234_5678, 1);
    do_op("div ovf", 2'b00, 32'h8000_0000,
          32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("rem ovf", 2'b10, 32'h8000_0000,
          32'hFFFF_FFFF, 32'h0, 1);

    // start held through CALC with new operands: the second
    // request must be taken exactly when the first one finishes.
    @(negedge clk);
    start    = 1'b1;
    op       = 2'b01;
    dividend = 32'd100;
    divisor  = 32'd7;
    @(posedge clk);
    #1;
    op       = 2'b00;
    dividend = 32'd1000;
    divisor  = 32'd3;
    check_op("held start", 32'd14, 33, 1'b0);
    start = 1'b0;
    check_op("back2back", 32'd333, 33, 1'b1);

    // Reset in the middle of a divide.
    launch(2'b01, 32'hFFFF_FFFF, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort result", result, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort no done", 32'(seen), 32'd0);
    do_op("divu 9/3", 2'b01, 32'd9, 32'd3,
          32'd3, 33);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      int          m;
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      m = int'($urandom_range(0, 9));
      if (m == 0) b = 32'd0;
      if (m == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      if (m == 2) b = 32'($urandom_range(1, 20));
      if (m == 3) b = -32'($urandom_range(1, 20));
      if (m == 4) a = 32'($urandom_range(0, 50));
      do_op($sformatf("rand%0d op%0d", i, o), o, a, b,
            model(o, a, b), lat_of(o, a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle integer divide/remainder unit for the RV32M DIV, DIVU, REM and REMU operations.
- It is the inverse counterpart of the single-cycle adder ALU: a restoring divider that produces one quotient bit per cycle by repeated trial subtraction.
- Sits beside the ALU in the execute stage. The control unit launches an operation with start, stalls on busy, and captures result on done.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when not busy.
- op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  input  WIDTH  first operand (rs1); sampled only on the accepting cycle.
- divisor  input  WIDTH  second operand (rs2); sampled only on the accepting cycle.
- busy  output  1  high while an operation is in progress (CALC state).
- done  output  1  single-cycle pulse marking result valid.
- result  output  WIDTH  quotient or remainder per op; held until the next accepted start.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0; internal registers cleared.
- Reset asserted mid-operation aborts immediately: no done pulse, outputs return to reset values next edge.
- States: IDLE, CALC, DONE.
- IDLE: start=1 -> latch op, |dividend| and |divisor| (raw values for unsigned ops), and sign flags.
  - Special case present -> DONE; otherwise -> CALC with counter=0.
- CALC:
  - Each cycle: shift {rem,quo} left by 1, trial-subtract the divisor from rem, keep the difference and set quo LSB=1 if non-negative, else restore.
  - counter increments each cycle; after WIDTH iterations (counter==WIDTH-1) -> DONE.
  - busy=1 throughout; start is ignored.
- DONE:
  - done=1 for exactly one cycle; result registered on entry.
  - start=1 in DONE is accepted (back-to-back issue); otherwise -> IDLE.
- Latency, with T0 = accepting edge:
  - Normal: CALC occupies T1..T32; done=1 in the cycle after T33.
  - Special cases: done=1 in the cycle after T1.
- Signed fix-up (DIV/REM):
  - Quotient negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Arithmetic is two's complement, WIDTH bits, wrap on negate.
- Special cases (RISC-V mandated, no trap):
  - Divisor 0: DIV/DIVU -> all ones (0xFFFFFFFF); REM/REMU -> dividend.
  - Signed overflow (dividend 0x80000000, divisor 0xFFFFFFFF, DIV/REM): DIV -> 0x80000000; REM -> 0.
- Operand inputs may change freely after the accepting cycle; the unit uses only latched copies.
- result remains stable in IDLE after done until a new start is accepted.

Decomposition:
- Shared package (alu_pkg):
  - XLEN constant (32).
  - div_op_t enum (DIV, DIVU, REM, REMU) with the encodings above.
  - div_state_t enum (IDLE, CALC, DONE).
- One natural combinational sub-module, div_step:
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: next remainder and quotient bit.
  - Keeps the iteration datapath separate from the FSM and counter.

Test Plan:
- DIVU 100/7, then REMU 100/7 -> result 14 (0x0000000E), then 2; done pulses after T33; busy high for exactly 32 cycles each.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); DIV 7 / 0xFFFFFFFE (-2) -> 0xFFFFFFFD.
- Divide by zero: DIVU 0x12345678/0 -> 0xFFFFFFFF; REM 0x12345678/0 -> 0x12345678; done after T1, busy never high.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; both with 1-cycle latency.
- Protocol:
  - start held high and operands changed during CALC -> ignored; result reflects the original operands.
  - start asserted in DONE -> new operation begins with no idle gap.
- Reset at cycle T10 of a DIVU -> busy=0, done never pulses, result=0; a subsequent DIVU 9/3 -> 3.
